// File: rtl/paint_pkg.sv
// Shared types and canvas constants for the brush painter and frame buffer.
// Used by brush_painter and span_clip.
package paint_pkg;

    localparam int WIDTH   = 200;
    localparam int HEIGHT  = 200;
    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;
    localparam int SIZE_W  = 3;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        CLEAR
    } paint_state_t;

    localparam color_t BLANK_COLOR = 3'b111;

endpackage

// File: rtl/brush_painter_span_clip.sv
// One-axis stamp span: centre +/- radius clipped to 0..limit-1.
// empty flags a centre that lies off the canvas.
module span_clip
    import paint_pkg::*;
(
    input  logic [COORD_W-1:0] centre,
    input  logic [SIZE_W-1:0]  radius,
    input  logic [COORD_W:0]   limit,
    output logic [COORD_W-1:0] lo,
    output logic [COORD_W-1:0] hi,
    output logic               empty
);

    localparam int SW = COORD_W + 2;

    logic signed [SW-1:0] c;
    logic signed [SW-1:0] r;
    logic signed [SW-1:0] l;
    logic signed [SW-1:0] lo_s;
    logic signed [SW-1:0] hi_s;

    assign c    = $signed({2'b00, centre});
    assign r    = $signed({{(SW-SIZE_W){1'b0}}, radius});
    assign l    = $signed({1'b0, limit});
    assign lo_s = c - r;
    assign hi_s = c + r;

    assign empty = (c >= l);
    assign lo    = lo_s[SW-1] ? '0 : coord_t'(lo_s);
    assign hi    = (hi_s >= l) ? coord_t'(l - SW'(1)) : coord_t'(hi_s);

endmodule

// File: rtl/brush_painter.sv
// Expands paint commands into one frame-buffer pixel write per clock.
// Define ROUND_BRUSH_EN to mask stamps to a disc of radius r.
module brush_painter
    import paint_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_clear,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic [SIZE_W-1:0]  req_size,
    input  logic [COLOR_W-1:0] req_color,
    output logic               brush,
    output logic [COORD_W-1:0] wx,
    output logic [COORD_W-1:0] wy,
    output logic [COLOR_W-1:0] newColor,
    output logic               busy
);

    paint_state_t state, state_n;
    coord_t x_lo, x_hi, y_hi;
    coord_t x_lo_n, x_hi_n, y_hi_n;
    coord_t wx_n, wy_n;
    color_t col_n;
    logic   brush_n, busy_n, ready_n;

    coord_t xlo_c, xhi_c, ylo_c, yhi_c;
    logic   xe, ye;

    span_clip u_xclip (
        .centre (req_x),
        .radius (req_size),
        .limit  ((COORD_W+1)'(WIDTH)),
        .lo     (xlo_c),
        .hi     (xhi_c),
        .empty  (xe)
    );

    span_clip u_yclip (
        .centre (req_y),
        .radius (req_size),
        .limit  ((COORD_W+1)'(HEIGHT)),
        .lo     (ylo_c),
        .hi     (yhi_c),
        .empty  (ye)
    );

`ifdef ROUND_BRUSH_EN
    coord_t            cx, cy;
    logic [SIZE_W-1:0] rad;

    function automatic logic hit(input coord_t x, input coord_t y,
                                 input coord_t ox, input coord_t oy,
                                 input logic [SIZE_W-1:0] r);
        int dx, dy;
        dx = int'(x) - int'(ox);
        dy = int'(y) - int'(oy);
        return (dx * dx + dy * dy) <= (int'(r) * int'(r));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cx  <= '0;
            cy  <= '0;
            rad <= '0;
        end else if (state == IDLE && req_valid) begin
            cx  <= req_x;
            cy  <= req_y;
            rad <= req_size;
        end
    end
`endif

    always_comb begin
        state_n = state;
        x_lo_n  = x_lo;
        x_hi_n  = x_hi;
        y_hi_n  = y_hi;
        wx_n    = wx;
        wy_n    = wy;
        col_n   = newColor;
        brush_n = 1'b0;
        busy_n  = busy;
        ready_n = req_ready;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    col_n   = req_color;
                    busy_n  = 1'b1;
                    ready_n = 1'b0;
                    if (req_clear) begin
                        state_n = CLEAR;
                        wx_n    = '0;
                        wy_n    = '0;
                        x_lo_n  = '0;
                        x_hi_n  = coord_t'(WIDTH - 1);
                        y_hi_n  = coord_t'(HEIGHT - 1);
                        brush_n = 1'b1;
                    end else if (xe || ye) begin
                        // Pin the end point to the held position: one silent cycle.
                        state_n = PAINT;
                        x_hi_n  = wx;
                        y_hi_n  = wy;
                    end else begin
                        state_n = PAINT;
                        wx_n    = xlo_c;
                        wy_n    = ylo_c;
                        x_lo_n  = xlo_c;
                        x_hi_n  = xhi_c;
                        y_hi_n  = yhi_c;
                        brush_n = 1'b1;
`ifdef ROUND_BRUSH_EN
                        brush_n = hit(xlo_c, ylo_c, req_x, req_y, req_size);
`endif
                    end
                end
            end
            PAINT, CLEAR: begin
                if (wx == x_hi && wy == y_hi) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end else begin
                    if (wx == x_hi) begin
                        wx_n = x_lo;
                        wy_n = wy + coord_t'(1);
                    end else begin
                        wx_n = wx + coord_t'(1);
                    end
                    brush_n = 1'b1;
`ifdef ROUND_BRUSH_EN
                    if (state == PAINT)
                        brush_n = hit(wx_n, wy_n, cx, cy, rad);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x_lo      <= '0;
            x_hi      <= '0;
            y_hi      <= '0;
            wx        <= '0;
            wy        <= '0;
            newColor  <= '0;
            brush     <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            x_lo      <= x_lo_n;
            x_hi      <= x_hi_n;
            y_hi      <= y_hi_n;
            wx        <= wx_n;
            wy        <= wy_n;
            newColor  <= col_n;
            brush     <= brush_n;
            busy      <= busy_n;
            req_ready <= ready_n;
        end
    end

endmodule

// File: tb/tb_brush_painter.sv
// Directed self-checking bench for brush_painter.
// Square-stamp scenarios run by default; the disc scenario under ROUND_BRUSH_EN.
module tb_brush_painter;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_clear;
    logic [7:0] req_x;
    logic [7:0] req_y;
    logic [2:0] req_size;
    logic [2:0] req_color;
    logic       brush;
    logic [7:0] wx;
    logic [7:0] wy;
    logic [2:0] newColor;
    logic       busy;

    int checks;
    int failures;

    brush_painter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_clear (req_clear),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_size  (req_size),
        .req_color (req_color),
        .brush     (brush),
        .wx        (wx),
        .wy        (wy),
        .newColor  (newColor),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic clr, input int x, input int y,
                        input int r, input int c);
        @(negedge clk);
        req_valid = 1'b1;
        req_clear = clr;
        req_x     = 8'(x);
        req_y     = 8'(y);
        req_size  = 3'(r);
        req_color = 3'(c);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_clear = 1'b0;
        req_x     = 8'd10;
        req_y     = 8'd10;
        req_size  = 3'd1;
        req_color = 3'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({brush, busy, req_ready, wx, wy, newColor} !== {1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 3'd0}) begin
            failures++;
            $display("FAIL reset_values: brush=%b busy=%b ready=%b wx=%0d wy=%0d col=%0d, want 0 0 1 0 0 0",
                     brush, busy, req_ready, wx, wy, newColor);
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || brush !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_beats_valid: busy=%b brush=%b ready=%b, want 0 0 1",
                     busy, brush, req_ready);
        end
    endtask

    task automatic test_stamp(input string name, input int x, input int y,
                              input int r, input int c, input int xlo, input int xhi,
                              input int ylo, input int yhi);
        int  w, h, n;
        bit  done;
        logic [7:0] ex, ey;
        w    = xhi - xlo + 1;
        h    = yhi - ylo + 1;
        n    = 0;
        done = 1'b0;
        send(1'b0, x, y, r, c);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
            end else begin
                ex = 8'(xlo + n % w);
                ey = 8'(ylo + n / w);
                checks++;
                if (brush !== 1'b1 || wx !== ex || wy !== ey || newColor !== 3'(c)) begin
                    failures++;
                    $display("FAIL %s_pix%0d: brush=%b (%0d,%0d) col=%0d, want 1 (%0d,%0d) col=%0d",
                             name, n, brush, wx, wy, newColor, ex, ey, c);
                end
                n++;
            end
        end
        checks++;
        if (!done || n != w * h) begin
            failures++;
            $display("FAIL %s_count: busy cycles=%0d done=%0d, want %0d", name, n, done, w * h);
        end
        checks++;
        if (brush !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_end: brush=%b ready=%b, want 0 1", name, brush, req_ready);
        end
    endtask

    task automatic test_clear();
        int  n, errs, rdy_errs;
        bit  done;
        logic [7:0] fx, fy, lx, ly;
        n = 0; errs = 0; rdy_errs = 0; done = 1'b0;
        fx = 8'hff; fy = 8'hff; lx = 8'hff; ly = 8'hff;
        send(1'b1, 0, 0, 0, 7);
        for (int i = 0; i < 40010 && !done; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
            end else begin
                if (req_ready !== 1'b0) rdy_errs++;
                if (brush !== 1'b1 || newColor !== 3'd7 ||
                    wx !== 8'(n % 200) || wy !== 8'(n / 200)) errs++;
                if (n == 0) begin fx = wx; fy = wy; end
                lx = wx; ly = wy;
                n++;
            end
        end
        checks++;
        if (!done || n != 40000) begin
            failures++;
            $display("FAIL clear_count: writes=%0d done=%0d, want 40000", n, done);
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL clear_raster: bad cycles=%0d, want 0", errs);
        end
        checks++;
        if (rdy_errs != 0) begin
            failures++;
            $display("FAIL clear_ready_low: ready-high cycles=%0d, want 0", rdy_errs);
        end
        checks++;
        if (fx !== 8'd0 || fy !== 8'd0 || lx !== 8'd199 || ly !== 8'd199) begin
            failures++;
            $display("FAIL clear_ends: first (%0d,%0d) last (%0d,%0d), want (0,0) (199,199)",
                     fx, fy, lx, ly);
        end
        checks++;
        if (req_ready !== 1'b1 || brush !== 1'b0 || newColor !== 3'd7) begin
            failures++;
            $display("FAIL clear_idle: ready=%b brush=%b col=%0d, want 1 0 7",
                     req_ready, brush, newColor);
        end
    endtask

    task automatic test_out_of_range();
        send(1'b0, 200, 5, 2, 3);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || brush !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL oob_pulse: busy=%b brush=%b ready=%b, want 1 0 0", busy, brush, req_ready);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || brush !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL oob_idle: busy=%b brush=%b ready=%b, want 0 0 1", busy, brush, req_ready);
        end
        checks++;
        if (wx !== 8'd199 || wy !== 8'd199) begin
            failures++;
            $display("FAIL oob_hold: (%0d,%0d), want (199,199)", wx, wy);
        end
    endtask

    task automatic test_reset_mid();
        send(1'b0, 50, 50, 2, 3);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wx !== 8'd51 || wy !== 8'd48) begin
            failures++;
            $display("FAIL mid_fourth: busy=%b (%0d,%0d), want 1 (51,48)", busy, wx, wy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({brush, busy, req_ready, wx, wy, newColor} !== {1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 3'd0}) begin
            failures++;
            $display("FAIL mid_abort: brush=%b busy=%b ready=%b wx=%0d wy=%0d col=%0d, want 0 0 1 0 0 0",
                     brush, busy, req_ready, wx, wy, newColor);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(1'b0, 5, 5, 0, 2);
        req_valid = 1'b1;
        req_clear = 1'b0;
        req_x     = 8'd100;
        req_y     = 8'd120;
        req_size  = 3'd0;
        req_color = 3'd6;
        @(negedge clk);
        checks++;
        if (brush !== 1'b1 || wx !== 8'd5 || wy !== 8'd5 || newColor !== 3'd2 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: brush=%b (%0d,%0d) col=%0d ready=%b, want 1 (5,5) 2 0",
                     brush, wx, wy, newColor, req_ready);
        end
        @(negedge clk);
        checks++;
        if (brush !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap: brush=%b busy=%b ready=%b, want 0 0 1", brush, busy, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (brush !== 1'b1 || wx !== 8'd100 || wy !== 8'd120 || newColor !== 3'd6) begin
            failures++;
            $display("FAIL b2b_second: brush=%b (%0d,%0d) col=%0d, want 1 (100,120) 6",
                     brush, wx, wy, newColor);
        end
        @(negedge clk);
        checks++;
        if (brush !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end: brush=%b ready=%b, want 0 1", brush, req_ready);
        end
    endtask

    task automatic test_round();
        int  pulses, cyc;
        bit  done;
        pulses = 0; cyc = 0; done = 1'b0;
        send(1'b0, 50, 50, 2, 1);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else begin
                cyc++;
                if (brush === 1'b1) pulses++;
            end
        end
        checks++;
        if (!done || pulses != 13 || cyc != 25) begin
            failures++;
            $display("FAIL round_disc: pulses=%0d cycles=%0d done=%0d, want 13 25", pulses, cyc, done);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_clear = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_size  = '0;
        req_color = '0;
        test_reset();
`ifndef ROUND_BRUSH_EN
        test_stamp("stamp10", 10, 10, 1, 5, 9, 11, 9, 11);
        test_stamp("corner", 0, 0, 2, 4, 0, 2, 0, 2);
        test_stamp("edge", 199, 199, 3, 1, 196, 199, 196, 199);
`else
        test_round();
`endif
        test_clear();
        test_out_of_range();
        test_reset_mid();
        test_stamp("restart", 20, 30, 0, 3, 20, 20, 30, 30);
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
